// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding and frame geometry.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, flags mid-start and end-of-bit.
// Latency: ticks are combinational decodes of the registered count.
// Backpressure: none; clr forces the count to 0 on the next edge.
module uart_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);
    // CLKS_PER_BIT must be at least 4 so HALF_BIT-1 and CLKS_PER_BIT-1 are distinct, non-negative counts
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at the end of a bit period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_tick = (cnt_q == CW'(HALF_BIT - 1));
    assign full_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start detect, mid-bit sampling, stop check, one parallel byte per frame.
// Latency: rx_valid HALF_BIT + 9*CLKS_PER_BIT + 2 cycles after start edge (+2 with UART_RX_SYNC_EN).
// Backpressure: none; rx_valid/frame_err are single-cycle pulses, consumer must take them.
// Optional input synchronizer selected by macro UART_RX_SYNC_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      serial_dat_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      rx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync1_q, sync1_d, sync2_q, sync2_d;

    // Two-stage synchronizer next values
    always_comb begin
        sync1_d = serial_dat_in;
        sync2_d = sync1_q;
    end

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign rx_s = sync2_q;
`else
    // Same-clock source only: line is used as-is
    assign rx_s = serial_dat_in;
`endif

    rx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
    // bit_idx[3] is the "all eight bits captured" flag; DATA leaves one cycle after it sets
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      timer_clr;
    logic                      half_tick, full_tick;

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // Timer restarts from 0 on every state entry and is parked while idle
    assign timer_clr = (state_d != state_q) || (state_q == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
            end
            START: begin
                // Mid-start re-check rejects short glitches
                if (half_tick) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_idx_q[3]) state_d = STOP;
            end
            STOP: begin
                if (full_tick) state_d = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                // A break or stuck-low line must return high before a new start is accepted
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: shift register, bit index, result pulses
    always_comb begin
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            START: begin
                if (half_tick && !rx_s) bit_idx_d = '0;
            end
            DATA: begin
                if (full_tick && !bit_idx_q[3]) begin
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q     <= '0;
            bit_idx_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
